// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin denominations, hopper select codes
// and payout controller state encoding.
package vm_pkg;

    localparam int DENOM_5 = 5;
    localparam int DENOM_2 = 2;
    localparam int DENOM_1 = 1;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_5    = 3'b100;
    localparam logic [2:0] COIN_2    = 3'b010;
    localparam logic [2:0] COIN_1    = 3'b001;

    typedef logic [2:0] pay_state_t;

    localparam pay_state_t ST_IDLE     = 3'd0;
    localparam pay_state_t ST_SELECT   = 3'd1;
    localparam pay_state_t ST_DISPENSE = 3'd2;
    localparam pay_state_t ST_DONE     = 3'd3;
    localparam pay_state_t ST_FAULT    = 3'd4;

endpackage

// File: rtl/ack_timer.sv
// Loadable down-counter; expire flags terminal count while counting is enabled.
module ack_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout controller: pays a requested amount with greedy 5/2/1 coins,
// one hopper request at a time, with a per-coin ack timeout.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | ready for a request
// SELECT   | pick largest coin that fits remaining
// DISPENSE | coin_req held, waiting for hopper ack
// DONE     | one-cycle done pulse
// FAULT    | hopper timed out, locked until reset
module change_payout_ctrl
    import vm_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int AMT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pay_valid,
    input  logic [AMT_W-1:0] pay_amount,
    output logic             pay_ready,
    output logic [2:0]       coin_req,
    input  logic             coin_ack,
    output logic [AMT_W-1:0] paid_total,
    output logic             done,
    output logic             fault
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    pay_state_t       state;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] cur_denom;
    logic [2:0]       sel_coin;
    logic             tmr_expire;

    always_comb begin
        sel_coin = COIN_1;
        if (remaining >= AMT_W'(DENOM_5)) begin
            sel_coin = COIN_5;
        end else if (remaining >= AMT_W'(DENOM_2)) begin
            sel_coin = COIN_2;
        end
    end

    // The denomination in flight is recovered from the held hopper select.
    always_comb begin
        cur_denom = AMT_W'(DENOM_1);
        if (coin_req[2]) begin
            cur_denom = AMT_W'(DENOM_5);
        end else if (coin_req[1]) begin
            cur_denom = AMT_W'(DENOM_2);
        end
    end

    ack_timer #(.W(TMR_W)) u_ack_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_SELECT),
        .en       (state == ST_DISPENSE),
        .load_val (TMR_W'(ACK_TIMEOUT - 1)),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            paid_total <= '0;
            coin_req   <= COIN_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pay_valid) begin
                        remaining  <= pay_amount;
                        paid_total <= '0;
                        state      <= (pay_amount == '0) ? ST_DONE : ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    coin_req <= sel_coin;
                    state    <= ST_DISPENSE;
                end
                ST_DISPENSE: begin
                    // An ack on the expiring cycle still counts as delivered.
                    if (coin_ack) begin
                        remaining  <= remaining - cur_denom;
                        paid_total <= paid_total + cur_denom;
                        coin_req   <= COIN_NONE;
                        state      <= (remaining == cur_denom) ? ST_DONE : ST_SELECT;
                    end else if (tmr_expire) begin
                        coin_req <= COIN_NONE;
                        state    <= ST_FAULT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state    <= ST_IDLE;
                    coin_req <= COIN_NONE;
                end
            endcase
        end
    end

    assign pay_ready = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    assign fault     = (state == ST_FAULT);

endmodule
